ps2_tx: RTL and testbench
=========================

Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter: the sending side of the PS/2 link whose receive side is `ps2`.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives PS2_CLK/PS2_DAT open-collector through two output-enable signals. The top level ties each pin as `oe ? 1'b0 : 1'bz`.
- Sits in the clock_25 domain beside `ps2`. The CPU triggers it through a memory-mapped port write.

Parameters:
- INHIBIT_CYCLES, 2500: clocks the host holds ps_clock low before the start bit (100 us at 25 MHz).
- TIMEOUT_CYCLES, 375000: maximum clocks allowed between device falling edges, and from clock release to the first edge (15 ms).

Ports:
- clock  in  1  system clock (clock_25)
- reset_n  in  1  asynchronous active-low reset
- ps_clock  in  1  raw PS2_CLK pin level
- ps_data  in  1  raw PS2_DAT pin level
- send  in  1  one-cycle request to transmit `data`
- data  in  8  byte to send; sampled only on an accepted `send`
- clk_oe  out  1  1 = pull PS2_CLK low
- dat_oe  out  1  1 = pull PS2_DAT low
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at the end of a transfer
- error  out  1  one-cycle pulse, coincident with `done`, when the device did not ACK or the transfer timed out

Behaviour:
- Reset (async, reset_n=0): state IDLE; clk_oe=0, dat_oe=0, busy=0, done=0, error=0; all counters 0.
- Input conditioning:
  - ps_clock and ps_data each pass through a 2-flop synchronizer.
  - A falling edge `fe` is synchronized clock 1 -> 0 across consecutive cycles.
  - All protocol decisions use the synchronized values.
- IDLE:
  - send=1 latches the shift register {stop=1, parity, data[7:0]}; parity = ~^data (odd).
  - Next cycle: busy=1, clk_oe=1, state INHIBIT.
  - send while busy=1 is ignored.
- INHIBIT:
  - Counts INHIBIT_CYCLES.
  - At the last count: dat_oe=1 (start bit), clk_oe=0 on the same edge, timer cleared, state WAIT.
- WAIT/BITS: bit counter n = 0..9.
  - On each `fe`: dat_oe = ~shift[n], n increments, timer cleared.
  - Edges 1-8 drive data bits LSB first. Edge 9 drives parity. Edge 10 drives stop, which releases the line (dat_oe=0).
  - After edge 10: state ACK.
- ACK:
  - On the next `fe`, sample synchronized ps_data. 0 = ACK; 1 = no-ACK, which sets a sticky error flag.
  - Then state RELEASE.
- RELEASE:
  - Wait until synchronized clock=1 and data=1.
  - Then one-cycle done=1, error=flag; busy=0 on the same cycle; state IDLE.
- Timeout:
  - In WAIT, BITS, ACK and RELEASE, the timer increments every cycle and clears on `fe`.
  - Reaching TIMEOUT_CYCLES: clk_oe=0, dat_oe=0, done=1, error=1, IDLE.
- clk_oe is asserted only in INHIBIT. dat_oe is never asserted in ACK, RELEASE or IDLE.
- Reset mid-transfer: both lines are released immediately (async), nothing is latched, done is not pulsed.
- Timer width: ceil(log2(TIMEOUT_CYCLES+1)) bits. It must not wrap before the limit.

Test Plan:
- Reset mid-INHIBIT -> clk_oe and dat_oe drop to 0 asynchronously; after release, busy=0 and no done pulse.
- send, data=0xED; device model clocks at 12.5 kHz, samples on rising edges, ACKs -> model receives start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Then done=1 and error=0 for exactly one cycle; clk_oe is high for exactly 2500 cycles beforehand.
- send, data=0x00 -> parity bit 1; data=0xFF -> parity bit 1; data=0x01 -> parity bit 0. All complete with error=0.
- Device model does not ACK (data stays high on edge 11) -> done=1 with error=1; lines are released.
- No device clock after release -> at 375000 cycles done=1, error=1, clk_oe=0, dat_oe=0, busy=0.
- send pulsed again while busy with data=0x55 during a 0xF4 transfer -> the model receives 0xF4 only, and exactly one done pulse occurs.

Source files
------------

// File: rtl/ps2_tx_if.sv
// Host-side PS/2 transmit bundle: raw pin levels in, open-collector enables
// and transfer handshake out.
interface ps2_tx_if;
  logic       ps_clock;
  logic       ps_data;
  logic       send;
  logic [7:0] data;
  logic       clk_oe;
  logic       dat_oe;
  logic       busy;
  logic       done;
  logic       error;

  modport slave (
    input  ps_clock, ps_data, send, data,
    output clk_oe, dat_oe, busy, done, error
  );

  modport master (
    output ps_clock, ps_data, send, data,
    input  clk_oe, dat_oe, busy, done, error
  );
endinterface

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues the start bit,
// shifts data/parity/stop on device falling edges, then checks the device ACK.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic     clock,
  input  logic     reset_n,
  ps2_tx_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_BITS    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [2:0]    r_state;
  logic [1:0]    r_clk_s, r_dat_s;
  logic          r_clk_d;
  logic [9:0]    r_shift;
  logic [3:0]    r_bit;
  logic [IW-1:0] r_inh;
  logic [TW-1:0] r_timer;
  logic          r_nack;
  logic          r_clk_oe, r_dat_oe, r_busy, r_done, r_error;

  logic w_clk, w_dat, w_fe;
  assign w_clk = r_clk_s[1];
  assign w_dat = r_dat_s[1];
  assign w_fe  = r_clk_d & ~w_clk;

  assign bus.clk_oe = r_clk_oe;
  assign bus.dat_oe = r_dat_oe;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.error  = r_error;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      // Idle bus level is high; starting the synchronizers there avoids a
      // phantom falling edge right after reset.
      r_clk_s  <= 2'b11;
      r_dat_s  <= 2'b11;
      r_clk_d  <= 1'b1;
      r_shift  <= '0;
      r_bit    <= '0;
      r_inh    <= '0;
      r_timer  <= '0;
      r_nack   <= 1'b0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_clk_s <= {r_clk_s[0], bus.ps_clock};
      r_dat_s <= {r_dat_s[0], bus.ps_data};
      r_clk_d <= w_clk;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.send) begin
            r_shift  <= {1'b1, ~^bus.data, bus.data};
            r_nack   <= 1'b0;
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_inh    <= '0;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_inh == I_LAST) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b1;
            r_timer  <= '0;
            r_bit    <= '0;
            r_state  <= S_WAIT;
          end else begin
            r_inh <= r_inh + 1'b1;
          end
        end
        S_WAIT, S_BITS, S_ACK, S_RELEASE: begin
          if (!w_fe && r_timer == T_LAST) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b1;
            r_error  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_timer <= w_fe ? '0 : r_timer + 1'b1;
            if (r_state == S_WAIT || r_state == S_BITS) begin
              if (w_fe) begin
                r_dat_oe <= ~r_shift[r_bit];
                r_bit    <= r_bit + 4'd1;
                r_state  <= (r_bit == 4'd9) ? S_ACK : S_BITS;
              end
            end else if (r_state == S_ACK) begin
              if (w_fe) begin
                r_nack  <= r_nack | w_dat;
                r_state <= S_RELEASE;
              end
            end else if (w_clk && w_dat) begin
              r_done  <= 1'b1;
              r_error <= r_nack;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a PS/2 device model that clocks the line,
// samples data on rising edges and optionally ACKs.
module tb_ps2_tx;
  localparam int INH  = 50;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_pulses = 0;
  int   done_hi = 0;
  int   clkoe_hi = 0;
  logic last_err = 1'b0;
  logic done_d = 1'b0;

  ps2_tx_if bus();
  assign bus.ps_clock = ~(bus.clk_oe | dev_clk_low);
  assign bus.ps_data  = ~(bus.dat_oe | dev_dat_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clk), .reset_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    done_d <= bus.done;
    if (bus.done) begin
      done_hi  <= done_hi + 1;
      last_err <= bus.error;
      if (!done_d) done_pulses <= done_pulses + 1;
    end
    if (bus.clk_oe) clkoe_hi <= clkoe_hi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    bus.data = d;
    bus.send = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
  endtask

  // Wait (bounded) for the inhibit pulse to end; returns cycles waited.
  task automatic wait_inhibit_end(output int k);
    bit seen;
    seen = 0;
    k = 0;
    while (k < INH + 100) begin
      @(negedge clk);
      k++;
      if (bus.clk_oe) seen = 1;
      else if (seen) break;
    end
  endtask

  task automatic dev_xfer(input bit ack, output logic [10:0] rx);
    int k;
    rx = '0;
    wait_inhibit_end(k);
    chk("inhibit_end", 32'(k < INH + 100), 32'd1);
    cyc(4);
    rx[0] = bus.ps_data;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      cyc(HALF);
      dev_clk_low = 1'b0;
      rx[i] = bus.ps_data;
      cyc(HALF);
    end
    dev_dat_low = ack;
    cyc(5);
    dev_clk_low = 1'b1;
    cyc(HALF);
    dev_clk_low = 1'b0;
    cyc(5);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int k;
    k = 0;
    while (done_pulses == base && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(done_pulses != base), 32'd1);
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack,
                          input logic [10:0] exp_frame, input string tag);
    int p0, h0, c0;
    logic [10:0] rx;
    p0 = done_pulses; h0 = done_hi; c0 = clkoe_hi;
    send_byte(d);
    dev_xfer(ack, rx);
    wait_done(p0, {tag, "_done_seen"});
    cyc(5);
    chk({tag, "_frame"},  32'(rx), 32'(exp_frame));
    chk({tag, "_pulses"}, done_pulses, p0 + 1);
    chk({tag, "_done_len"}, done_hi - h0, 1);
    chk({tag, "_error"},  32'(last_err), 32'(!ack));
    chk({tag, "_inhibit"}, clkoe_hi - c0, INH);
    chk({tag, "_busy"},   32'(bus.busy), 32'd0);
    chk({tag, "_lines"},  32'({bus.clk_oe, bus.dat_oe}), 32'd0);
  endtask

  initial begin
    int p0, k;
    logic [10:0] rx;
    bus.send = 1'b0;
    bus.data = 8'h00;
    cyc(3);
    chk("rst_clk_oe", 32'(bus.clk_oe), 32'd0);
    chk("rst_dat_oe", 32'(bus.dat_oe), 32'd0);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_error",  32'(bus.error),  32'd0);
    rst_n = 1'b1;
    cyc(3);

    // Reset in the middle of the inhibit window
    p0 = done_pulses;
    send_byte(8'hED);
    cyc(10);
    chk("mid_inh_clk_oe", 32'(bus.clk_oe), 32'd1);
    chk("mid_inh_busy",   32'(bus.busy),   32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lines", 32'({bus.clk_oe, bus.dat_oe}), 32'd0);
    chk("async_rst_busy",  32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(INH + 20);
    chk("post_rst_busy",   32'(bus.busy), 32'd0);
    chk("post_rst_clk_oe", 32'(bus.clk_oe), 32'd0);
    chk("post_rst_nodone", done_pulses, p0);

    // Frames as received LSB-first: {stop, parity, data, start}
    run_xfer(8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, "xED");
    run_xfer(8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, "x00");
    run_xfer(8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, "xFF");
    run_xfer(8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, "x01");
    run_xfer(8'hED, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, "nack");

    // No device clock at all: timeout counted from the clock release
    p0 = done_pulses;
    send_byte(8'h12);
    wait_inhibit_end(k);
    chk("to_inhibit_end", 32'(k < INH + 100), 32'd1);
    k = 0;
    while (k < TMO + 50) begin
      @(negedge clk);
      k++;
      if (bus.done) break;
    end
    chk("to_cycles", k, TMO);
    chk("to_error",  32'(bus.error), 32'd1);
    chk("to_busy",   32'(bus.busy),  32'd0);
    chk("to_lines",  32'({bus.clk_oe, bus.dat_oe}), 32'd0);
    cyc(5);
    chk("to_pulses", done_pulses, p0 + 1);

    // A second send while busy must be dropped
    begin
      int c0;
      p0 = done_pulses;
      c0 = clkoe_hi;
      send_byte(8'hF4);
      cyc(10);
      send_byte(8'h55);
      dev_xfer(1'b1, rx);
      wait_done(p0, "busy_done_seen");
      cyc(INH + 20);
      chk("busy_frame",   32'(rx), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
      chk("busy_pulses",  done_pulses, p0 + 1);
      chk("busy_error",   32'(last_err), 32'd0);
      chk("busy_inhibit", clkoe_hi - c0, INH);
      chk("busy_idle",    32'({bus.busy, bus.clk_oe, bus.dat_oe}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
